dcm_prog_ctrl: RTL and testbench

DCM_PROG_CTRL -- requirements
Module: dcm_prog_ctrl

---
 rtl/mm_dcm_pkg.sv | 35 +++
 rtl/dcm_prog_ctrl_if.sv | 10 +
 rtl/dcm_prog_shift.sv | 39 +++
 rtl/dcm_prog_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dcm_prog_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mm_dcm_pkg.sv
// Shared state encoding, command patterns and frame lengths for the DCM reprogramming controller.
package mm_dcm_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoadD,
        StGapD,
        StLoadM,
        StGapM,
        StGo,
        StWaitDone,
        StWaitLock,
        StRun,
        StDcmRst
    } dcm_state_e;

    localparam int unsigned FrameLen = 10;
    localparam int unsigned GapLen   = 2;
    localparam int unsigned GoLen    = 1;
    localparam int unsigned MaxTries = 3;

    // Bit 0 goes out first: D frame starts 1,0 and M frame starts 1,1.
    localparam logic [1:0] CmdD = 2'b01;
    localparam logic [1:0] CmdM = 2'b11;

    localparam int unsigned MmClkMul = 4;
    localparam logic [7:0]  DefMul   = 8'(MmClkMul - 1);
    localparam logic [7:0]  DefDiv   = 8'd0;

    function automatic logic [FrameLen-1:0] make_frame(input logic [1:0] cmd,
                                                       input logic [7:0] val);
        return {val, cmd};
    endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// M/D request handshake between a client and the DCM reprogramming controller.
interface dcm_prog_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_mul;
    logic [7:0] cfg_div;

    modport master (output cfg_valid, output cfg_mul, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_mul, input cfg_div, output cfg_ready);
endinterface

// File: rtl/dcm_prog_shift.sv
// 10-bit load/shift serializer; done strobes during the last bit of a frame.
module dcm_prog_shift
    import mm_dcm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [FrameLen-1:0] frame,
    output logic                sdata,
    output logic                done
);

    logic [FrameLen-1:0] sr_q;
    logic [3:0]          idx_q;
    logic                active_q;

    assign sdata = sr_q[0];
    assign done  = active_q && (idx_q == 4'(FrameLen - 1));

    // Zeros shift in behind the frame so the line idles low once it is sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            sr_q     <= frame;
            idx_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            sr_q  <= sr_q >> 1;
            idx_q <= idx_q + 4'd1;
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Programs DCM M/D over PROGEN/PROGDATA, waits for PROGDONE/LOCKED and gates the output clock.
// PROGCLK is ~clk at the top level, so the DCM samples these registered outputs mid-cycle.
module dcm_prog_ctrl
    import mm_dcm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned RST_CYC     = 8
) (
    input  logic           clk,
    input  logic           rst,
    dcm_prog_ctrl_if.slave cfg,
    output logic           dcm_progen,
    output logic           dcm_progdata,
    input  logic           dcm_progdone,
    input  logic           dcm_locked,
    output logic           dcm_rst,
    output logic           clk25m_on,
    output logic           busy,
    output logic           err
);

    // RST_CYC is assumed to fit the timeout counter, which it shares.
    localparam int unsigned    CW        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0]  TmoLast   = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]  RstLast   = CW'(RST_CYC - 1);
    localparam logic [1:0]     RetryLast = 2'(MaxTries - 1);

    dcm_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0] retry_q, retry_d;
    logic [7:0] mul_q, mul_d, div_q, div_d;
    logic boot_q, boot_d, err_q, err_d;
    logic progen_q, dcm_rst_q, clk_on_q, busy_q, ready_q;
    logic accept, timed_out, shift_load, shift_done;
    logic [FrameLen-1:0] shift_frame;

    assign accept  = cfg.cfg_valid && ready_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        retry_d     = retry_q;
        err_d       = err_q;
        mul_d       = mul_q;
        div_d       = div_q;
        boot_d      = boot_q;
        shift_load  = 1'b0;
        shift_frame = make_frame(CmdD, div_q);
        timed_out   = 1'b0;
        if (accept && cfg.cfg_mul == 8'd0) begin
            err_d = 1'b1;
        end else if (accept) begin
            mul_d       = cfg.cfg_mul;
            div_d       = cfg.cfg_div;
            err_d       = 1'b0;
            retry_d     = '0;
            state_d     = StLoadD;
            shift_load  = 1'b1;
            shift_frame = make_frame(CmdD, cfg.cfg_div);
        end else begin
            unique case (state_q)
                StIdle: begin
                    // The reset cycle itself counts as the first DCM reset cycle.
                    if (boot_q) begin
                        boot_d  = 1'b0;
                        state_d = StDcmRst;
                        cnt_d   = CW'(1);
                    end
                end
                StLoadD: if (shift_done) begin state_d = StGapD; cnt_d = '0; end
                StGapD: begin
                    if (cnt_q >= CW'(GapLen - 1)) begin
                        state_d     = StLoadM;
                        shift_load  = 1'b1;
                        shift_frame = make_frame(CmdM, mul_q);
                    end
                end
                StLoadM: if (shift_done) begin state_d = StGapM; cnt_d = '0; end
                StGapM: if (cnt_q >= CW'(GapLen - 1)) begin state_d = StGo; cnt_d = '0; end
                StGo: if (cnt_q >= CW'(GoLen - 1)) begin state_d = StWaitDone; cnt_d = '0; end
                StWaitDone: begin
                    if (dcm_progdone) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q >= TmoLast) begin
                        timed_out = 1'b1;
                    end
                end
                StWaitLock: begin
                    if (dcm_locked) begin
                        state_d = StRun;
                        retry_d = '0;
                    end else if (cnt_q >= TmoLast) begin
                        timed_out = 1'b1;
                    end
                end
                StRun: if (!dcm_locked) begin state_d = StDcmRst; cnt_d = '0; end
                StDcmRst: begin
                    if (cnt_q >= RstLast) begin
                        state_d    = StLoadD;
                        shift_load = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (timed_out) begin
                err_d = 1'b1;
                cnt_d = '0;
                if (retry_q == RetryLast) begin
                    state_d = StIdle;
                    retry_d = '0;
                end else begin
                    state_d = StDcmRst;
                    retry_d = retry_q + 2'd1;
                end
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            retry_q   <= '0;
            mul_q     <= DefMul;
            div_q     <= DefDiv;
            boot_q    <= 1'b1;
            err_q     <= 1'b0;
            progen_q  <= 1'b0;
            dcm_rst_q <= 1'b1;
            clk_on_q  <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            mul_q     <= mul_d;
            div_q     <= div_d;
            boot_q    <= boot_d;
            err_q     <= err_d;
            progen_q  <= (state_d == StLoadD) || (state_d == StLoadM) || (state_d == StGo);
            dcm_rst_q <= (state_d == StDcmRst);
            clk_on_q  <= (state_d == StRun);
            busy_q    <= !((state_d == StIdle) || (state_d == StRun));
            ready_q   <= (state_d == StIdle) || (state_d == StRun);
        end
    end

    dcm_prog_shift u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (shift_load),
        .frame (shift_frame),
        .sdata (dcm_progdata),
        .done  (shift_done)
    );

    assign cfg.cfg_ready = ready_q;
    assign dcm_progen    = progen_q;
    assign dcm_rst       = dcm_rst_q;
    assign clk25m_on     = clk_on_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed/randomized bench for dcm_prog_ctrl with a cycle-level model of the programming frames.
module tb_dcm_prog_ctrl;
    import mm_dcm_pkg::*;

    localparam int unsigned TMO  = 16;
    localparam int unsigned RSTC = 8;

    logic clk = 1'b0;
    logic rst, progdone, locked;
    logic dcm_progen, dcm_progdata, dcm_rst, clk25m_on, busy, err;
    int checks = 0;
    int errors = 0;
    int cur_m, cur_d;

    always #5 clk = ~clk;

    dcm_prog_ctrl_if cfg_if ();

    dcm_prog_ctrl #(
        .TIMEOUT_CYC (TMO),
        .RST_CYC     (RSTC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg_if.slave),
        .dcm_progen   (dcm_progen),
        .dcm_progdata (dcm_progdata),
        .dcm_progdone (progdone),
        .dcm_locked   (locked),
        .dcm_rst      (dcm_rst),
        .clk25m_on    (clk25m_on),
        .busy         (busy),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wire image of one full program: D frame, gap, M frame, gap, GO.
    task automatic expect_program(input int m, input int d);
        for (int c = 0; c < 25; c++) begin
            int en, dat, k;
            en = 0;
            dat = 0;
            if (c < 10) begin
                en = 1;
                dat = (c == 0) ? 1 : (c == 1) ? 0 : (d >> (c - 2)) % 2;
            end else if (c >= 12 && c < 22) begin
                k = c - 12;
                en = 1;
                dat = (k < 2) ? 1 : (m >> (k - 2)) % 2;
            end else if (c == 24) begin
                en = 1;
            end
            check($sformatf("progen[%0d]", c), dcm_progen, en);
            check($sformatf("progdata[%0d]", c), dcm_progdata, dat);
            check($sformatf("busy_prog[%0d]", c), busy, 1);
            tick();
        end
        check("progen_wait_done", dcm_progen, 0);
        check("busy_wait_done", busy, 1);
    endtask

    task automatic count_dcm_rst(input string tag);
        int n = 0;
        while (dcm_rst === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check(tag, n, RSTC);
    endtask

    // DCM answers PROGDONE after dd cycles, then LOCKED after dl more.
    task automatic run_dcm(input int dd, input int dl, input int exp_err);
        repeat (dd) begin
            check("progen_idle_wait", dcm_progen, 0);
            tick();
        end
        progdone = 1'b1;
        tick();
        progdone = 1'b0;
        repeat (dl) begin
            check("clk_on_before_lock", clk25m_on, 0);
            tick();
        end
        locked = 1'b1;
        check("clk_on_at_lock", clk25m_on, 0);
        tick();
        check("clk_on_after_lock", clk25m_on, 1);
        check("busy_run", busy, 0);
        check("err_run", err, exp_err);
        check("ready_run", cfg_if.cfg_ready, 1);
        check("dcm_rst_run", dcm_rst, 0);
    endtask

    // Locked is dropped together with the request, exercising request-over-lock-loss priority.
    task automatic request(input int m, input int d);
        check("ready_before_req", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mul = m[7:0];
        cfg_if.cfg_div = d[7:0];
        locked = 1'b0;
        tick();
        cfg_if.cfg_valid = 1'b0;
        if (m != 0) begin
            cur_m = m;
            cur_d = d;
            check("clk_on_after_req", clk25m_on, 0);
            check("dcm_rst_after_req", dcm_rst, 0);
            check("err_after_req", err, 0);
        end
    endtask

    initial begin
        int m, d;
        rst = 1'b1;
        progdone = 1'b0;
        locked = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mul = 8'd0;
        cfg_if.cfg_div = 8'd0;
        repeat (3) tick();
        check("rst_progen", dcm_progen, 0);
        check("rst_progdata", dcm_progdata, 0);
        check("rst_dcm_rst", dcm_rst, 1);
        check("rst_clk_on", clk25m_on, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);

        // Boot: reset pulse then the default M/D is programmed unprompted.
        rst = 1'b0;
        count_dcm_rst("boot_dcm_rst_len");
        cur_m = MmClkMul - 1;
        cur_d = 0;
        expect_program(cur_m, cur_d);
        run_dcm(5, $urandom_range(1, 12), 0);

        // M==0 is rejected with err but leaves RUN untouched.
        request(0, 5);
        locked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mul0_err", err, 1);
            check("mul0_progen", dcm_progen, 0);
            check("mul0_clk_on", clk25m_on, 1);
            tick();
        end

        for (int i = 0; i < 3; i++) begin
            m = $urandom_range(1, 255);
            d = $urandom_range(0, 255);
            if (i == 0) begin
                m = 8'h13;
                d = 8'h01;
            end
            request(m, d);
            expect_program(m, d);
            run_dcm($urandom_range(0, 10), $urandom_range(0, 12), 0);
        end

        // Lock loss in RUN: clock gated next cycle, DCM reset, same M/D reprogrammed.
        repeat (3) tick();
        locked = 1'b0;
        tick();
        check("lockloss_clk_on", clk25m_on, 0);
        check("lockloss_busy", busy, 1);
        count_dcm_rst("lockloss_dcm_rst_len");
        expect_program(cur_m, cur_d);
        run_dcm($urandom_range(0, 10), $urandom_range(0, 12), 0);

        // PROGDONE never arrives: two retries then park in IDLE.
        request($urandom_range(1, 255), $urandom_range(0, 255));
        expect_program(cur_m, cur_d);
        for (int attempt = 0; attempt < 3; attempt++) begin
            repeat (TMO - 1) tick();
            check("tmo_err_before", err, (attempt > 0) ? 1 : 0);
            tick();
            check("tmo_err_after", err, 1);
            check("tmo_progen", dcm_progen, 0);
            if (attempt < 2) begin
                check("tmo_dcm_rst", dcm_rst, 1);
                count_dcm_rst("tmo_dcm_rst_len");
                expect_program(cur_m, cur_d);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    check("park_dcm_rst", dcm_rst, 0);
                    check("park_busy", busy, 0);
                    check("park_ready", cfg_if.cfg_ready, 1);
                    check("park_err", err, 1);
                    tick();
                end
            end
        end

        // Reset mid LOAD_M aborts, then the boot sequence reprograms the defaults.
        request($urandom_range(1, 255), $urandom_range(0, 255));
        repeat (14) tick();
        check("pre_abort_progen", dcm_progen, 1);
        rst = 1'b1;
        tick();
        check("abort_progen", dcm_progen, 0);
        check("abort_progdata", dcm_progdata, 0);
        check("abort_clk_on", clk25m_on, 0);
        check("abort_busy", busy, 0);
        check("abort_dcm_rst", dcm_rst, 1);
        tick();
        rst = 1'b0;
        count_dcm_rst("reboot_dcm_rst_len");
        expect_program(MmClkMul - 1, 0);
        run_dcm($urandom_range(0, 10), $urandom_range(0, 12), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
